// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported instructions into HALT.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        dm_ready,
  output logic        PCWR,
  output logic        IRWR,
  output logic        RFWR,
  output logic        DMWR,
  output logic        dm_req,
  output logic [2:0]  NPCOP,
  output logic [2:0]  ALUOP,
  output logic [1:0]  EXTOP,
  output logic [1:0]  M1,
  output logic [1:0]  M2,
  output logic        M3,
  output logic [1:0]  WBH,
  output logic [2:0]  state,
  output logic        done,
  output logic [31:0] retired,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    InsAlu, InsLoad, InsStore, InsBeq, InsJ, InsJal, InsJr, InsBad
  } ins_e;

  state_e      state_q, state_d;
  ins_e        ins;
  logic [2:0]  alu_sel;
  logic [1:0]  ext_sel;
  logic [1:0]  wbh_sel;
  logic        imm_sel;
  logic        pcwr_c, irwr_c, rfwr_c, dmwr_c, dmreq_c;
  logic [31:0] retired_q;

  // Instruction class and per-instruction datapath selects, decoded from the IR fields.
  always_comb begin
    ins     = InsBad;
    alu_sel = 3'b000;
    ext_sel = 2'b00;
    wbh_sel = 2'b00;
    imm_sel = 1'b0;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100001: ins = InsAlu;
          6'b100011: begin ins = InsAlu; alu_sel = 3'b001; end
          6'b101011: begin ins = InsAlu; alu_sel = 3'b011; end
          6'b000000: begin ins = InsAlu; alu_sel = 3'b100; end
          6'b001000: ins = InsJr;
          default:   ins = InsBad;
        endcase
      end
      6'b001101: begin ins = InsAlu; alu_sel = 3'b010; ext_sel = 2'b01; imm_sel = 1'b1; end
      6'b001111: begin ins = InsAlu; ext_sel = 2'b10; imm_sel = 1'b1; end
      6'b001000: begin ins = InsAlu; imm_sel = 1'b1; end
      6'b100011: begin ins = InsLoad; imm_sel = 1'b1; end
      6'b100000: begin ins = InsLoad; imm_sel = 1'b1; wbh_sel = 2'b01; end
      6'b100001: begin ins = InsLoad; imm_sel = 1'b1; wbh_sel = 2'b10; end
      6'b101011: begin ins = InsStore; imm_sel = 1'b1; end
      6'b101000: begin ins = InsStore; imm_sel = 1'b1; wbh_sel = 2'b01; end
      6'b101001: begin ins = InsStore; imm_sel = 1'b1; wbh_sel = 2'b10; end
      6'b000100: begin ins = InsBeq; alu_sel = 3'b001; end
      6'b000010: ins = InsJ;
      6'b000011: ins = InsJal;
      default:   ins = InsBad;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pcwr_c  = 1'b0;
    irwr_c  = 1'b0;
    rfwr_c  = 1'b0;
    dmwr_c  = 1'b0;
    dmreq_c = 1'b0;
    NPCOP   = 3'b000;
    ALUOP   = 3'b000;
    EXTOP   = 2'b00;
    M1      = 2'b00;
    M2      = 2'b00;
    M3      = 1'b0;
    WBH     = 2'b00;
    done    = 1'b0;
    // Operand selects stay stable for the whole execute/memory/writeback span.
    if (state_q inside {StExec, StMem, StWb}) begin
      ALUOP = alu_sel;
      EXTOP = ext_sel;
      M3    = imm_sel;
      WBH   = wbh_sel;
    end
    case (state_q)
      StFetch: begin
        pcwr_c  = 1'b1;
        irwr_c  = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (ins != InsBad) begin
          state_d = StExec;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StFetch;
          done    = 1'b1;
`endif
        end
      end
      StExec: begin
        state_d = StFetch;
        case (ins)
          InsAlu:            state_d = StWb;
          InsLoad, InsStore: state_d = StMem;
          InsBeq: begin
            NPCOP  = 3'b001;
            pcwr_c = zero;
            done   = 1'b1;
          end
          InsJ: begin
            NPCOP  = 3'b010;
            pcwr_c = 1'b1;
            done   = 1'b1;
          end
          InsJal: begin
            NPCOP  = 3'b010;
            pcwr_c = 1'b1;
            rfwr_c = 1'b1;
            M1     = 2'b10;
            M2     = 2'b10;
            done   = 1'b1;
          end
          InsJr: begin
            NPCOP  = 3'b011;
            pcwr_c = 1'b1;
            done   = 1'b1;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        dmreq_c = 1'b1;
        dmwr_c  = (ins == InsStore);
        if (dm_ready) begin
          if (ins == InsLoad) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            done    = 1'b1;
          end
        end
      end
      StWb: begin
        rfwr_c  = 1'b1;
        M1      = (opcode == 6'b000000) ? 2'b01 : 2'b00;
        M2      = (ins == InsLoad) ? 2'b01 : 2'b00;
        done    = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        state_d = StHalt;
`else
        state_d = StFetch;
`endif
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 32'd0;
    end else if (done) begin
      retired_q <= retired_q + 32'd1;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_q == StDecode && ins == InsBad) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Reset is asynchronous, so enables are gated combinationally while it is held.
  assign PCWR    = pcwr_c & ~reset;
  assign IRWR    = irwr_c & ~reset;
  assign RFWR    = rfwr_c & ~reset;
  assign DMWR    = dmwr_c & ~reset;
  assign dm_req  = dmreq_c & ~reset;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
